bw_mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single `mult8bw` 8x8 signed Baugh-Wooley multiplier among up to 8 requesters. It accepts one operand pair per grant, registers the operands ahead of the combinational multiplier and registers the product behind it. The product is returned on a single valid/ready result port tagged with the requester index. The block sits between the requesting datapath units and the one multiplier instance, which is instantiated inside it.

---
 rtl/bw_mult_arbiter.sv | 152 +++++++++++++++
 tb/tb_bw_mult_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bw_mult_arbiter.sv
// Round-robin arbiter that time-shares one 8x8 signed Baugh-Wooley multiplier
// among NREQ requesters, returning tagged products on a valid/ready port.

module mult8bw (
  input  logic signed [7:0]  a,
  input  logic signed [7:0]  b,
  output logic signed [15:0] p
);

  // Inverting the partial products that carry exactly one sign bit, plus the
  // 2^8 + 2^15 correction, turns the unsigned array into a signed product.
  function automatic logic signed [15:0] bw_product(input logic signed [7:0] x,
                                                    input logic signed [7:0] y);
    logic [15:0] acc;
    logic        pp;
    acc = 16'h8100;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        pp = x[i] & y[j];
        if ((i == 7) != (j == 7)) pp = ~pp;
        acc = acc + (pp ? (16'd1 << (i + j)) : 16'd0);
      end
    end
    return signed'(acc);
  endfunction

  always_comb begin
    p = bw_product(a, b);
  end

endmodule

module bw_mult_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*8-1:0]      a_in,
  input  logic [NREQ*8-1:0]      b_in,
  output logic [NREQ-1:0]        gnt,
  output logic                   busy,
  output logic                   res_valid,
  output logic [IDW-1:0]         res_id,
  output logic signed [15:0]     res_p,
  input  logic                   res_ready
);

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [IDW-1:0]            last_id;
  logic                      accept;
  logic                      win_found;
  logic [IDW-1:0]            win_id;
  logic [NREQ-1:0]           win_oh;
  logic                      gnt_any;
  int                        cand;
  logic signed [DATA_W-1:0]  a_sel;
  logic signed [DATA_W-1:0]  b_sel;
  logic signed [DATA_W-1:0]  a_p0;
  logic signed [DATA_W-1:0]  b_p0;
  logic [IDW-1:0]            id_p0;
  logic signed [2*DATA_W-1:0] prod_p1;

  // Search starts just after the last winner and wraps at NREQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(last_id) + 1 + k) % NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!win_found && (i == cand) && req[i]) begin
          win_found = 1'b1;
          win_id    = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    win_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_oh[i] = win_found && (win_id == IDW'(i));
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == IDW'(i)) begin
        a_sel = a_in[DATA_W*i +: DATA_W];
        b_sel = b_in[DATA_W*i +: DATA_W];
      end
    end
  end

  assign accept  = (state == IDLE) || ((state == DONE) && res_ready);
  assign gnt_any = accept && win_found && rst_n;
  assign gnt     = gnt_any ? win_oh : '0;

  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);

  mult8bw u_mult (
    .a (a_p0),
    .b (b_p0),
    .p (prod_p1)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any) state_nxt = CALC;
      CALC:    state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = gnt_any ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0: operands captured on grant; p1: product captured at the end of CALC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      last_id <= IDW'(NREQ - 1);
      a_p0    <= '0;
      b_p0    <= '0;
      id_p0   <= '0;
      res_p   <= '0;
      res_id  <= '0;
    end else begin
      state <= state_nxt;
      if (gnt_any) begin
        last_id <= win_id;
        a_p0    <= a_sel;
        b_p0    <= b_sel;
        id_p0   <= win_id;
      end
      if (state == CALC) begin
        res_p  <= prod_p1;
        res_id <= id_p0;
      end
    end
  end

endmodule

// File: tb/tb_bw_mult_arbiter.sv
// Scoreboard bench for bw_mult_arbiter: directed scenarios plus random traffic
// checked against a cycle-level reference model of the arbitration rules.

module tb_bw_mult_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*8-1:0]     a_in;
  logic [NREQ*8-1:0]     b_in;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  res_valid;
  logic [IDW-1:0]        res_id;
  logic signed [15:0]    res_p;
  logic                  res_ready;

  always #5 clk = ~clk;

  bw_mult_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .busy      (busy),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_p     (res_p),
    .res_ready (res_ready)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {int id; logic [15:0] p;} exp_t;
  exp_t sbq[$];

  // Model: 0 = nothing in flight, 1 = computing, 2 = result held
  int   m_phase    = 0;
  int   m_last     = NREQ - 1;
  logic m_rst_prev = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [NREQ-1:0] exp_g;
    int              win;
    int              idx;
    logic            acc_m;
    int              pa;
    int              pb;
    exp_t            e;
    if (!rst_n) begin
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_valid", 32'(res_valid), 32'(m_phase == 2));
      if (!m_rst_prev) begin
        chk("rst_res_p", {16'h0, res_p}, 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
      end
      m_phase = 0;
      m_last  = NREQ - 1;
      sbq.delete();
    end else begin
      acc_m = (m_phase == 0) || ((m_phase == 2) && res_ready);
      exp_g = '0;
      win   = -1;
      if (acc_m) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_last + 1 + k) % NREQ;
          if (win < 0 && req[idx]) win = idx;
        end
      end
      if (win >= 0) exp_g[win] = 1'b1;
      chk("gnt", 32'(gnt), 32'(exp_g));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("res_valid", 32'(res_valid), 32'(m_phase == 2));
      if (m_phase == 2) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard result expected but queue empty at %0t", $time);
        end else begin
          chk("res_id", 32'(res_id), 32'(sbq[0].id));
          chk("res_p", {16'h0, res_p}, {16'h0, sbq[0].p});
          if (res_ready) void'(sbq.pop_front());
        end
      end
      if (win >= 0) begin
        pa   = $signed(a_in[8*win +: 8]);
        pb   = $signed(b_in[8*win +: 8]);
        e.id = win;
        e.p  = 16'(pa * pb);
        sbq.push_back(e);
        m_last = win;
      end
      case (m_phase)
        0:       if (win >= 0) m_phase = 1;
        1:       m_phase = 2;
        default: if (res_ready) m_phase = (win >= 0) ? 1 : 0;
      endcase
    end
    m_rst_prev = rst_n;
  end

  // Driver state: per-requester pending flag and operands
  logic [NREQ-1:0] pend;
  logic [7:0]      av[NREQ];
  logic [7:0]      bv[NREQ];
  logic [NREQ-1:0] g_s;
  logic            v_s;
  logic [IDW-1:0]  id_s;
  logic [15:0]     p_s;

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i]          = pend[i];
      a_in[8*i +: 8]  = av[i];
      b_in[8*i +: 8]  = bv[i];
    end
  endtask

  task automatic step();
    @(negedge clk);
    g_s  = gnt;
    v_s  = res_valid;
    id_s = res_id;
    p_s  = res_p;
    @(posedge clk);
    #1;
    pend = pend & ~g_s;
    drive();
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
    pend[i] = 1'b1;
    av[i]   = a;
    bv[i]   = b;
  endtask

  task automatic all_req();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'($urandom), 8'($urandom));
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while (pend != 0 && n < limit) begin
      step();
      n++;
    end
    chk(name, 32'(pend), 32'd0);
  endtask

  task automatic wait_grant(input string name, input int limit);
    int n;
    n = 0;
    step();
    while (g_s == 0 && n < limit) begin
      step();
      n++;
    end
    chk(name, 32'(g_s != 0), 32'd1);
  endtask

  logic [7:0]  ca[5] = '{8'h80, 8'h7F, 8'hFF, 8'h03, 8'h00};
  logic [7:0]  cb[5] = '{8'h80, 8'h7F, 8'hFF, 8'hFB, 8'hB3};
  logic [15:0] cp[5] = '{16'h4000, 16'h3F01, 16'h0001, 16'hFFF1, 16'h0000};

  initial begin
    int n;
    int cyc;
    int last_cyc;
    logic [15:0] p_hold;
    logic [IDW-1:0] id_hold;

    // Reset held with every requester asking
    rst_n     = 1'b0;
    res_ready = 1'b1;
    pend      = '0;
    all_req();
    drive();
    repeat (3) step();
    rst_n = 1'b1;
    drive();
    step();
    chk("first_gnt_after_reset", 32'(g_s), 32'd1);
    drain("drain_after_reset", 40);
    repeat (4) step();

    // Single operation from requester 2
    set_req(2, 8'h80, 8'h7F);
    drive();
    step();
    chk("single_gnt", 32'(g_s), 32'b0100);
    step();
    chk("single_latency_not_early", 32'(v_s), 32'd0);
    step();
    chk("single_valid", 32'(v_s), 32'd1);
    chk("single_id", 32'(id_s), 32'd2);
    chk("single_p", 32'(p_s), 32'h0000C080);
    repeat (3) step();

    // Fairness after a fresh reset: order 0,1,2,3,0,1,2,3 every other cycle
    rst_n = 1'b0;
    drive();
    step();
    rst_n = 1'b1;
    all_req();
    drive();
    n = 0; cyc = 0; last_cyc = 0;
    while (n < 8 && cyc < 40) begin
      step();
      cyc++;
      if (g_s != 0) begin
        chk("rr_order", 32'(g_s), 32'(1 << (n % NREQ)));
        if (n > 0) chk("rr_spacing", 32'(cyc - last_cyc), 32'd2);
        last_cyc = cyc;
        n++;
        for (int i = 0; i < NREQ; i++)
          if (g_s[i]) set_req(i, 8'($urandom), 8'($urandom));
        drive();
      end
    end
    chk("rr_grant_count", 32'(n), 32'd8);
    pend = '0;
    drive();
    repeat (4) step();

    // Corner operand values
    for (int c = 0; c < 5; c++) begin
      set_req(c % NREQ, ca[c], cb[c]);
      drive();
      wait_grant("corner_grant", 10);
      step();
      step();
      chk("corner_valid", 32'(v_s), 32'd1);
      chk("corner_p", 32'(p_s), 32'(cp[c]));
      repeat (2) step();
    end

    // Backpressure with other requests pending
    res_ready = 1'b0;
    all_req();
    drive();
    n = 0;
    step();
    while (!v_s && n < 10) begin
      step();
      n++;
    end
    chk("bp_valid_seen", 32'(v_s), 32'd1);
    p_hold  = p_s;
    id_hold = id_s;
    repeat (5) begin
      step();
      chk("bp_gnt_blocked", 32'(g_s), 32'd0);
      chk("bp_p_stable", 32'(p_s), 32'(p_hold));
      chk("bp_id_stable", 32'(id_s), 32'(id_hold));
    end
    res_ready = 1'b1;
    step();
    chk("bp_regrant_same_cycle", 32'(g_s != 0), 32'd1);
    pend = '0;
    drive();
    repeat (4) step();

    // Reset during CALC
    all_req();
    drive();
    wait_grant("midrst_grant", 10);
    rst_n = 1'b0;
    drive();
    step();
    chk("midrst_no_valid_calc", 32'(v_s), 32'd0);
    rst_n = 1'b1;
    all_req();
    drive();
    step();
    chk("midrst_no_valid_after", 32'(v_s), 32'd0);
    chk("midrst_gnt_req0", 32'(g_s), 32'd1);
    pend = '0;
    drive();
    repeat (4) step();

    // Random traffic with random backpressure
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) set_req(i, 8'($urandom), 8'($urandom));
      res_ready = ($urandom_range(0, 3) != 0);
      drive();
      step();
    end
    pend      = '0;
    res_ready = 1'b1;
    drive();
    repeat (6) step();
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
